// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: forwarding selects, hazard FSM encoding,
// immediate-format codes and the register-match helper.
package riscv_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // A later-stage write can feed an operand only if it targets a real register
    function automatic logic reg_hit(input logic       we,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand EX forwarding select: Memory-stage result beats Writeback result.
module fwd_sel
    import riscv_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    output logic [1:0] sel_o
);

    // Priority comparator for one source operand
    always_comb begin
        sel_o = FWD_RF;
        if (reg_hit(reg_write_m_i, rd_m_i, rs_e_i)) begin
            sel_o = FWD_MEM;
        end else if (reg_hit(reg_write_w_i, rd_w_i, rs_e_i)) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding, load-use stall
// stretched over LOAD_LAT cycles, and branch flush. HAZ_PERF_EN adds perf counters.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LOAD_LAT - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fwd_a_s, fwd_b_s;
    logic             lw_haz_s;

    fwd_sel u_fwd_a (
        .rs_e_i        (Rs1E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_a_s)
    );

    fwd_sel u_fwd_b (
        .rs_e_i        (Rs2E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_b_s)
    );

    assign lw_haz_s = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // State and bubble counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the cycle that detects the hazard is the first bubble
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HZ_RUN: begin
                if (PCSrcE) begin
                    state_d = HZ_RUN;
                    cnt_d   = '0;
                end else if (lw_haz_s && (LOAD_LAT > 1)) begin
                    state_d = HZ_STALL;
                    cnt_d   = LAT_M1;
                end else begin
                    state_d = HZ_RUN;
                    cnt_d   = cnt_q;
                end
            end
            HZ_STALL: begin
                if (PCSrcE) begin
                    state_d = HZ_RUN;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = HZ_RUN;
                    cnt_d   = '0;
                end else begin
                    state_d = HZ_STALL;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = HZ_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Stall/flush/forward outputs from state and current inputs
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            ForwardAE = fwd_a_s;
            ForwardBE = fwd_b_s;
            case (state_q)
                HZ_RUN: begin
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (lw_haz_s) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end else begin
                        FlushE = 1'b0;
                    end
                end
                HZ_STALL: begin
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                default: begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating stall-cycle and branch-flush counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (StallF && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (PCSrcE && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
